// File: rtl/accel_issue_pkg.sv
// Shared types for the accelerator issue unit: FSM states and error causes.
package accel_issue_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } issue_state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_TAG_MISMATCH = 2'd1,
    ERR_SPURIOUS     = 2'd2,
    ERR_TIMEOUT      = 2'd3
  } err_cause_e;

endpackage

// File: rtl/accel_tag_fifo.sv
// Expected-tag FIFO: tags of requests still awaiting an in-order accelerator response.
module accel_tag_fifo
  import accel_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type TagType_t = logic [4:0]
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clear_i,
  input  logic     push_i,
  input  TagType_t data_i,
  input  logic     pop_i,
  output TagType_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  TagType_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (!push_i && pop_i) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/accel_issue_unit.sv
// Issues core instructions to an accelerator, checks in-order response tags and
// buffers one writeback; tag errors, spurious responses and timeouts are sticky.
//   state   | meaning
//   ST_RUN  | issuing requests and accepting responses
//   ST_ERR  | error latched; handshakes blocked until flush, pending writeback drains
module accel_issue_unit
  import accel_issue_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned IMM_WIDTH      = 11,
  parameter type         TagType_t      = logic [4:0],
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [WIDTH-1:0]     issue_rs1_i,
  input  logic [IMM_WIDTH-1:0] issue_imm_i,
  input  TagType_t             issue_tag_i,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [WIDTH-1:0]     acc_rs1_o,
  output logic [IMM_WIDTH-1:0] acc_imm_o,
  output TagType_t             acc_tag_o,
  input  logic                 acc_valid_i,
  output logic                 acc_ready_o,
  input  logic [WIDTH-1:0]     acc_result_i,
  input  TagType_t             acc_tag_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [WIDTH-1:0]     wb_result_o,
  output TagType_t             wb_tag_o,
  output logic                 acc_flush_o,
  output logic                 err_o,
  output logic [1:0]           err_cause_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  issue_state_e    state_q, state_d;
  err_cause_e      cause_q, cause_d;
  logic            err_q, err_set;
  logic            run, push, pop, rsp_fire, tag_hit, timeout_hit;
  logic            fifo_full, fifo_empty, wb_valid_q;
  TagType_t        fifo_head;
  logic [WD_W-1:0] wd_q;

  assign run           = (state_q == ST_RUN);
  assign acc_valid_o   = issue_valid_i & run & ~fifo_full;
  assign issue_ready_o = acc_ready_i & run & ~fifo_full;
  assign acc_rs1_o     = issue_rs1_i;
  assign acc_imm_o     = issue_imm_i;
  assign acc_tag_o     = issue_tag_i;
  assign acc_flush_o   = flush_i;
  assign acc_ready_o   = run & (~wb_valid_q | wb_ready_i);

  // Fires coinciding with a flush must leave no trace.
  assign push        = acc_valid_o & acc_ready_i & ~flush_i;
  assign rsp_fire    = acc_valid_i & acc_ready_o;
  assign tag_hit     = ~fifo_empty & (acc_tag_i == fifo_head);
  assign pop         = rsp_fire & tag_hit & ~flush_i;
  assign timeout_hit = ~fifo_empty & ~pop & (wd_q == WD_W'(TIMEOUT_CYCLES - 2));

  assign wb_valid_o  = wb_valid_q;
  assign err_o       = err_q;
  assign err_cause_o = cause_q;

  accel_tag_fifo #(
    .DEPTH    (DEPTH),
    .TagType_t(TagType_t)
  ) u_tag_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(flush_i),
    .push_i (push),
    .data_i (issue_tag_i),
    .pop_i  (pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    cause_d = ERR_NONE;
    if (run) begin
      if (rsp_fire && fifo_empty) begin
        err_set = 1'b1;
        cause_d = ERR_SPURIOUS;
      end else if (rsp_fire && !tag_hit) begin
        err_set = 1'b1;
        cause_d = ERR_TAG_MISMATCH;
      end else if (timeout_hit) begin
        err_set = 1'b1;
        cause_d = ERR_TIMEOUT;
      end
    end
    if (err_set) state_d = ST_ERR;
    if (flush_i) begin
      state_d = ST_RUN;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else if (flush_i) begin
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else if (err_set && !err_q) begin
      err_q   <= 1'b1;
      cause_q <= cause_d;
    end
  end

  // Watchdog saturates so it cannot wrap while sitting in ST_ERR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              wd_q <= '0;
    else if (flush_i || fifo_empty || pop)    wd_q <= '0;
    else if (wd_q != WD_W'(TIMEOUT_CYCLES - 1)) wd_q <= wd_q + WD_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q  <= 1'b0;
      wb_result_o <= '0;
      wb_tag_o    <= '0;
    end else if (flush_i) begin
      wb_valid_q  <= 1'b0;
    end else if (pop) begin
      wb_valid_q  <= 1'b1;
      wb_result_o <= acc_result_i;
      wb_tag_o    <= acc_tag_i;
    end else if (wb_ready_i) begin
      wb_valid_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accel_issue_unit.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_accel_issue_unit;

  localparam int WIDTH = 32;
  localparam int IMM_W = 11;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef logic [4:0] tag_t;

  logic             clk_i, rst_ni, flush_i;
  logic             issue_valid_i, issue_ready_o;
  logic [WIDTH-1:0] issue_rs1_i;
  logic [IMM_W-1:0] issue_imm_i;
  tag_t             issue_tag_i;
  logic             acc_valid_o, acc_ready_i;
  logic [WIDTH-1:0] acc_rs1_o;
  logic [IMM_W-1:0] acc_imm_o;
  tag_t             acc_tag_o;
  logic             acc_valid_i, acc_ready_o;
  logic [WIDTH-1:0] acc_result_i;
  tag_t             acc_tag_i;
  logic             wb_valid_o, wb_ready_i;
  logic [WIDTH-1:0] wb_result_o;
  tag_t             wb_tag_o;
  logic             acc_flush_o, err_o;
  logic [1:0]       err_cause_o;

  int checks   = 0;
  int failures = 0;

  accel_issue_unit #(
    .WIDTH(WIDTH), .IMM_WIDTH(IMM_W), .TagType_t(tag_t),
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs1_i(issue_rs1_i), .issue_imm_i(issue_imm_i), .issue_tag_i(issue_tag_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .acc_rs1_o(acc_rs1_o), .acc_imm_o(acc_imm_o), .acc_tag_o(acc_tag_o),
    .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .acc_result_i(acc_result_i), .acc_tag_i(acc_tag_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_tag_o(wb_tag_o),
    .acc_flush_o(acc_flush_o), .err_o(err_o), .err_cause_o(err_cause_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic idle();
    flush_i = 0; issue_valid_i = 0; issue_rs1_i = '0; issue_imm_i = '0; issue_tag_i = '0;
    acc_ready_i = 1; acc_valid_i = 0; acc_result_i = '0; acc_tag_i = '0; wb_ready_i = 1;
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1;
    tick();
    flush_i = 0;
  endtask

  task automatic issue(input tag_t t);
    issue_valid_i = 1; issue_tag_i = t; issue_rs1_i = $urandom; acc_ready_i = 1;
    tick();
    issue_valid_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle();
    issue_valid_i = 1;
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid_o); end
    checks++; if (err_o !== 1'b0 || err_cause_o !== 2'd0) begin failures++; $display("FAIL reset_err got=%0b/%0d exp=0/0", err_o, err_cause_o); end
    checks++; if (wb_result_o !== '0 || wb_tag_o !== '0) begin failures++; $display("FAIL reset_wb_data got=%h/%0d exp=0/0", wb_result_o, wb_tag_o); end
    checks++; if (acc_ready_o !== 1'b1 || acc_valid_o !== 1'b1 || issue_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_handshakes got=%0b%0b%0b exp=111", acc_ready_o, acc_valid_o, issue_ready_o); end
    tick();
    rst_ni = 1;
    idle();
    tick();
  endtask

  task automatic test_single_op();
    do_flush();
    issue_valid_i = 1; issue_tag_i = 5'd3; issue_rs1_i = 32'hCAFE_0001; issue_imm_i = 11'h2A;
    settle();
    checks++; if (acc_valid_o !== 1'b1 || issue_ready_o !== 1'b1 || acc_tag_o !== 5'd3 ||
                  acc_rs1_o !== 32'hCAFE_0001 || acc_imm_o !== 11'h2A) begin
      failures++; $display("FAIL single_issue got=%0b%0b tag=%0d rs1=%h imm=%h", acc_valid_o, issue_ready_o, acc_tag_o, acc_rs1_o, acc_imm_o); end
    tick();
    issue_valid_i = 0;
    wb_ready_i = 0;
    repeat (5) tick();
    acc_valid_i = 1; acc_tag_i = 5'd3; acc_result_i = 32'h55;
    settle();
    checks++; if (acc_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      failures++; $display("FAIL single_rsp_ready got=%0b/%0b exp=1/0", acc_ready_o, wb_valid_o); end
    tick();
    acc_valid_i = 0;
    settle();
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'h55 || wb_tag_o !== 5'd3 || err_o !== 1'b0) begin
      failures++; $display("FAIL single_wb got=%0b res=%h tag=%0d err=%0b exp=1/55/3/0", wb_valid_o, wb_result_o, wb_tag_o, err_o); end
    wb_ready_i = 1;
    tick();
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL single_wb_clear got=%0b exp=0", wb_valid_o); end
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < DEPTH; i++) issue(tag_t'(i));
    issue_valid_i = 1; issue_tag_i = 5'd4;
    settle();
    checks++; if (issue_ready_o !== 1'b0 || acc_valid_o !== 1'b0) begin
      failures++; $display("FAIL full_block got=%0b/%0b exp=0/0", issue_ready_o, acc_valid_o); end
    acc_valid_i = 1; acc_tag_i = 5'd0; acc_result_i = 32'h1234;
    tick();
    acc_valid_i = 0;
    settle();
    checks++; if (issue_ready_o !== 1'b1 || acc_valid_o !== 1'b1 || wb_tag_o !== 5'd0 || wb_valid_o !== 1'b1) begin
      failures++; $display("FAIL full_reopen got=%0b/%0b wb=%0b tag=%0d exp=1/1/1/0", issue_ready_o, acc_valid_o, wb_valid_o, wb_tag_o); end
    tick();
    issue_valid_i = 0;
    settle();
    checks++; if (issue_ready_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL full_again got=%0b err=%0b exp=0/0", issue_ready_o, err_o); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] r;
    r = $urandom;
    do_flush();
    issue(5'd7);
    wb_ready_i = 0;
    acc_valid_i = 1; acc_tag_i = 5'd7; acc_result_i = r;
    tick();
    acc_valid_i = 0; acc_result_i = ~r;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++; if (acc_ready_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_result_o !== r || wb_tag_o !== 5'd7) begin
        failures++; $display("FAIL bp_hold cyc=%0d ready=%0b wb=%0b res=%h exp=0/1/%h", i, acc_ready_o, wb_valid_o, wb_result_o, r); end
      tick();
    end
    wb_ready_i = 1;
    settle();
    checks++; if (acc_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", acc_ready_o); end
    tick();
    settle();
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", wb_valid_o); end
  endtask

  task automatic test_mismatch();
    do_flush();
    issue(5'd1);
    issue(5'd2);
    acc_valid_i = 1; acc_tag_i = 5'd2; acc_result_i = 32'hDEAD;
    tick();
    issue_valid_i = 1; issue_tag_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (err_o !== 1'b1 || err_cause_o !== 2'd1) begin
        failures++; $display("FAIL mismatch_err cyc=%0d got=%0b/%0d exp=1/1", i, err_o, err_cause_o); end
      checks++; if (acc_valid_o !== 1'b0 || issue_ready_o !== 1'b0 || acc_ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin
        failures++; $display("FAIL mismatch_hs got=%0b%0b%0b%0b exp=0000", acc_valid_o, issue_ready_o, acc_ready_o, wb_valid_o); end
      tick();
    end
    idle();
  endtask

  task automatic test_timeout();
    do_flush();
    issue(5'd5);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 14) begin
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0b exp=0", err_o); end
      end
    end
    checks++; if (err_o !== 1'b1 || err_cause_o !== 2'd3) begin
      failures++; $display("FAIL timeout_err got=%0b/%0d exp=1/3", err_o, err_cause_o); end
  endtask

  task automatic test_flush();
    do_flush();
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    flush_i = 1; acc_valid_i = 1; acc_tag_i = 5'd10; acc_result_i = 32'hF00D;
    issue_valid_i = 1; issue_tag_i = 5'd13;
    settle();
    checks++; if (acc_flush_o !== 1'b1) begin failures++; $display("FAIL flush_pass got=%0b exp=1", acc_flush_o); end
    tick();
    idle();
    settle();
    checks++; if (wb_valid_o !== 1'b0 || err_o !== 1'b0 || err_cause_o !== 2'd0 || acc_flush_o !== 1'b0) begin
      failures++; $display("FAIL flush_clear wb=%0b err=%0b/%0d fl=%0b exp=0/0/0/0", wb_valid_o, err_o, err_cause_o, acc_flush_o); end
    acc_valid_i = 1; acc_tag_i = 5'd10;
    tick();
    acc_valid_i = 0;
    checks++; if (err_o !== 1'b1 || err_cause_o !== 2'd2) begin
      failures++; $display("FAIL flush_empty_spurious got=%0b/%0d exp=1/2", err_o, err_cause_o); end
    do_flush();
  endtask

  task automatic test_random();
    tag_t             m_q[$];
    bit               m_wbv, m_err, e_av, e_ir, e_ar, rsp, req, pop;
    logic [WIDTH-1:0] m_res;
    tag_t             m_tag;
    logic [1:0]       m_cause;
    int               m_age;
    do_flush();
    m_wbv = 0; m_err = 0; m_cause = 0; m_age = 0; m_res = '0; m_tag = '0;
    for (int c = 0; c < 3000; c++) begin
      issue_valid_i = ($urandom_range(0, 1) == 1);
      issue_rs1_i   = $urandom;
      issue_imm_i   = IMM_W'($urandom);
      issue_tag_i   = tag_t'($urandom);
      acc_ready_i   = ($urandom_range(0, 3) != 0);
      acc_valid_i   = (m_q.size() == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      acc_tag_i     = (m_q.size() > 0 && $urandom_range(0, 9) != 0) ? m_q[0] : tag_t'($urandom);
      acc_result_i  = $urandom;
      wb_ready_i    = ($urandom_range(0, 3) != 0);
      flush_i       = m_err ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      settle();
      e_av = issue_valid_i && !m_err && m_q.size() < DEPTH;
      e_ir = acc_ready_i && !m_err && m_q.size() < DEPTH;
      e_ar = !m_err && (!m_wbv || wb_ready_i);
      checks++; if (acc_valid_o !== e_av || issue_ready_o !== e_ir || acc_ready_o !== e_ar) begin
        failures++; $display("FAIL rnd_hs cyc=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, acc_valid_o, issue_ready_o, acc_ready_o, e_av, e_ir, e_ar); end
      checks++; if ({acc_rs1_o, acc_imm_o, acc_tag_o, acc_flush_o} !== {issue_rs1_i, issue_imm_i, issue_tag_i, flush_i}) begin
        failures++; $display("FAIL rnd_pass cyc=%0d rs1=%h tag=%0d fl=%0b", c, acc_rs1_o, acc_tag_o, acc_flush_o); end
      checks++; if (wb_valid_o !== m_wbv || (m_wbv && (wb_result_o !== m_res || wb_tag_o !== m_tag))) begin
        failures++; $display("FAIL rnd_wb cyc=%0d got=%0b/%h/%0d exp=%0b/%h/%0d", c, wb_valid_o, wb_result_o, wb_tag_o, m_wbv, m_res, m_tag); end
      checks++; if (err_o !== m_err || err_cause_o !== m_cause) begin
        failures++; $display("FAIL rnd_err cyc=%0d got=%0b/%0d exp=%0b/%0d", c, err_o, err_cause_o, m_err, m_cause); end
      if (flush_i) begin
        m_q.delete(); m_wbv = 0; m_err = 0; m_cause = 0; m_age = 0;
      end else begin
        rsp = acc_valid_i && e_ar;
        req = e_av && acc_ready_i;
        pop = rsp && m_q.size() > 0 && acc_tag_i == m_q[0];
        if (!m_err) begin
          if (rsp && m_q.size() == 0)                            begin m_err = 1; m_cause = 2'd2; end
          else if (rsp && !pop)                                  begin m_err = 1; m_cause = 2'd1; end
          else if (m_q.size() > 0 && !pop && m_age + 1 == TO - 1) begin m_err = 1; m_cause = 2'd3; end
        end
        if (m_q.size() == 0 || pop) m_age = 0;
        else if (m_age < TO - 1)    m_age++;
        if (pop) begin
          m_wbv = 1; m_res = acc_result_i; m_tag = acc_tag_i;
          void'(m_q.pop_front());
        end else if (m_wbv && wb_ready_i) begin
          m_wbv = 0;
        end
        if (req) m_q.push_back(issue_tag_i);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_full();
    test_backpressure();
    test_mismatch();
    test_timeout();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
